prism_seq_ctrl: RTL and testbench
=================================

Name: prism_seq_ctrl

Overview:
- Sequencing controller for the PRISM FSM engine inside the TinyQV peripheral.
- Owns the PRISM debug write port, debug_reset and fsm_enable.
- Host software queues (address, data) configuration words into a small FIFO, then issues start. The block resets PRISM, streams the queued words into it, releases reset, enables the FSM and raises an interrupt on the first halt.
- Direct host writes share the same PRISM write port with priority over the loader.

Parameters:
- FIFO_DEPTH, 4, configuration FIFO entries; power of two, minimum 2.
- RESET_CYCLES, 2, cycles prism_reset is held in RESET state; minimum 1.
- ADDR_W, 6, PRISM debug address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_start  input  1  single-cycle pulse; begins a load/run sequence
- cmd_abort  input  1  single-cycle pulse; returns to IDLE from any state
- push_valid  input  1  host offers a config word
- push_ready  output  1  FIFO can accept; equals !full
- push_addr  input  ADDR_W  PRISM debug address of the queued word
- push_data  input  32  PRISM debug data of the queued word
- host_wr  input  1  direct host write to PRISM
- host_addr  input  ADDR_W  direct write address
- host_wdata  input  32  direct write data
- prism_addr  output  ADDR_W  to PRISM debug_addr
- prism_wr  output  1  to PRISM debug_wr
- prism_wdata  output  32  to PRISM debug_wdata
- prism_reset  output  1  to PRISM debug_reset
- prism_enable  output  1  to PRISM fsm_enable
- prism_halt  input  1  PRISM debug_halt_either
- irq_clr  input  1  clears done_irq
- done_irq  output  1  sticky halt interrupt
- busy  output  1  state is not IDLE and not DONE
- state  output  3  IDLE=0, RESET=1, LOAD=2, START=3, RUN=4, DONE=5
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, FIFO empty, halt_r=0.
  - All outputs 0 except push_ready=1.
- All prism_* outputs and done_irq are registered.
- Write arbitration:
  - A write decided at cycle t appears on prism_wr/addr/wdata at t+1 for exactly one cycle.
  - host_wr=1 at t always wins, in every state.
  - Otherwise, in LOAD with the FIFO non-empty, the loader pops the head entry at t and drives it at t+1.
  - prism_wr=0 otherwise; prism_addr/prism_wdata hold their last values.
- FIFO:
  - Push when push_valid && push_ready.
  - A push while full is dropped; push_ready is low then, even if a pop occurs in the same cycle.
  - Simultaneous push and pop with 0<level<FIFO_DEPTH leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_abort flushes the FIFO (level=0).
- FSM transitions:
  - IDLE/DONE: cmd_start -> RESET, load the counter with RESET_CYCLES, clear done_irq. cmd_start in any other state is ignored.
  - RESET: prism_reset=1, prism_enable=0. Counter decrements each cycle; on reaching 0 -> LOAD.
  - LOAD: prism_reset stays 1. Exit to START when the FIFO is empty and no loader write was decided this cycle. A LOAD entered with an empty FIFO lasts 1 cycle.
  - START: prism_reset=0 for one cycle, then -> RUN.
  - RUN: prism_enable=1.
    - halt_r <= prism_halt every cycle.
    - Rising edge (prism_halt && !halt_r) -> DONE, done_irq=1, prism_enable=0.
    - A halt level already high on RUN entry does not fire until it falls and rises again. halt_r continuously tracks prism_halt, so this holds automatically.
  - DONE: outputs idle; prism_enable=0, prism_reset=0.
- cmd_abort:
  - Any state -> IDLE next cycle, prism_enable=0, prism_reset=0, FIFO flushed.
  - done_irq is unaffected.
  - Abort wins over a simultaneous cmd_start.
- done_irq:
  - Set on the halt edge; cleared by irq_clr or cmd_start.
  - Set wins over a same-cycle irq_clr.
- Pushes during RUN/DONE are accepted and retained for the next start.

Optional Feature:
- Macro: PRISM_SEQ_CKSUM_EN.
- When defined:
  - Adds output cksum (32): XOR of all prism_wdata values written by the loader (not host writes) since the last cmd_start.
  - cmd_start clears it to 0; rst clears it to 0.
  - It updates in the same cycle prism_wr is driven by a loader write.
- When undefined: the port is absent and there is no checksum logic.

Test Plan:
- Push (0x04,0xA5A50001), (0x08,0x0000FFFF), then cmd_start; RESET_CYCLES=2 -> prism_reset high 2 cycles; two prism_wr pulses with those values in order; then START, RUN with prism_enable=1, state=4.
- In RUN, raise prism_halt -> next cycle state=5, done_irq=1, prism_enable=0. Pulse irq_clr together with a second halt edge in a later run -> done_irq remains 1.
- Queue 3 words, hold host_wr=1 (addr 0x10, data 0x1234) for 2 cycles during LOAD -> host writes appear first; the loader resumes after; fifo_level drops 3->0; all 5 writes seen.
- Push 5 words with FIFO_DEPTH=4 -> push_ready=0 at level 4, the 5th is dropped, fifo_level=4.
- cmd_start and cmd_abort together in LOAD with 2 words queued -> state=0, fifo_level=0, prism_reset=0, no further prism_wr.
- With PRISM_SEQ_CKSUM_EN, load 0xFF00FF00 and 0x0F0F0F0F -> cksum=0xF00FF00F; next cmd_start -> cksum=0.

Source files
------------

// File: rtl/prism_seq_ctrl.sv
// -----------------------------------------------------------------------------
// prism_seq_ctrl
//
// Sequencing controller for the PRISM FSM engine in the TinyQV peripheral.
// The host queues (address, data) configuration words into a small FIFO and
// then issues cmd_start. The controller then:
//   1. holds PRISM in reset for RESET_CYCLES cycles,
//   2. streams every queued word into the PRISM debug write port,
//   3. releases reset for one START cycle,
//   4. enables the FSM (RUN) until the first rising edge of prism_halt,
//   5. raises a sticky done_irq and parks in DONE.
// Direct host writes share the PRISM write port and always win over the loader.
//
// Optional feature (macro PRISM_SEQ_CKSUM_EN):
//   Adds output cksum, the XOR of every loader-written prism_wdata value since
//   the last accepted cmd_start. When the macro is undefined the port and its
//   logic are absent.
//
// Parameters:
//   FIFO_DEPTH   configuration FIFO entries (power of two, >= 2)
//   RESET_CYCLES cycles prism_reset is held in the RESET state (>= 1)
//   ADDR_W       PRISM debug address width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_start, cmd_abort     single-cycle command pulses
//   push_valid/ready/addr/data  configuration FIFO push interface
//   host_wr/addr/wdata       direct host write to PRISM (highest priority)
//   prism_addr/wr/wdata      registered PRISM debug write port
//   prism_reset, prism_enable  registered PRISM debug_reset / fsm_enable
//   prism_halt               PRISM debug_halt_either
//   irq_clr, done_irq        sticky halt interrupt and its clear
//   busy                     state is neither IDLE nor DONE
//   state                    IDLE=0 RESET=1 LOAD=2 START=3 RUN=4 DONE=5
//   fifo_level               current FIFO occupancy
//   cksum                    (PRISM_SEQ_CKSUM_EN only) loader write checksum
// -----------------------------------------------------------------------------
module prism_seq_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int RESET_CYCLES = 2,
    parameter int ADDR_W       = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_start,
    input  logic                          cmd_abort,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [31:0]                   push_data,
    input  logic                          host_wr,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [31:0]                   host_wdata,
    output logic [ADDR_W-1:0]             prism_addr,
    output logic                          prism_wr,
    output logic [31:0]                   prism_wdata,
    output logic                          prism_reset,
    output logic                          prism_enable,
    input  logic                          prism_halt,
    input  logic                          irq_clr,
    output logic                          done_irq,
    output logic                          busy,
    output logic [2:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PRISM_SEQ_CKSUM_EN
    ,
    output logic [31:0]                   cksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                halt_q, halt_d;
    logic                done_irq_q, done_irq_d;
    logic                prism_wr_q, prism_wr_d;
    logic [ADDR_W-1:0]   prism_addr_q, prism_addr_d;
    logic [31:0]         prism_wdata_q, prism_wdata_d;
    logic                prism_reset_q, prism_reset_d;
    logic                prism_enable_q, prism_enable_d;

    // FIFO storage carries data only, so it is left out of reset.
    logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
    logic [31:0]         data_mem [FIFO_DEPTH];

    logic                fifo_full;
    logic                fifo_empty;
    logic                push_fire;
    logic                load_pop;
    logic                start_acc;
    logic                halt_rise;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    // An abort flushes the FIFO, so a push offered in that same cycle is lost.
    assign push_fire  = push_valid && !fifo_full && !cmd_abort;
    assign start_acc  = cmd_start && !cmd_abort &&
                        ((state_q == S_IDLE) || (state_q == S_DONE));
    assign halt_rise  = prism_halt && !halt_q;

    // ------------------------------------------------------------------
    // Next-state, loader and interrupt logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_pop   = 1'b0;
        done_irq_d = done_irq_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d = S_RESET;
                    cnt_d   = CNT_W'(RESET_CYCLES);
                end
            end
            S_RESET: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A host write steals the port; the loader just waits a cycle.
                if (fifo_empty) begin
                    state_d = S_START;
                end else if (!host_wr) begin
                    load_pop = 1'b1;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_rise) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_abort) begin
            state_d  = S_IDLE;
            load_pop = 1'b0;
        end

        // Setting on the halt edge takes precedence over a same-cycle clear.
        if ((state_q == S_RUN) && halt_rise && !cmd_abort) begin
            done_irq_d = 1'b1;
        end else if (irq_clr || start_acc) begin
            done_irq_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers / level
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (cmd_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (load_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_fire) - LVL_W'(load_pop);
        end
    end

    // ------------------------------------------------------------------
    // Registered PRISM-side outputs, derived from the next state so they
    // line up with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        prism_wr_d     = host_wr || load_pop;
        prism_addr_d   = prism_addr_q;
        prism_wdata_d  = prism_wdata_q;
        if (host_wr) begin
            prism_addr_d  = host_addr;
            prism_wdata_d = host_wdata;
        end else if (load_pop) begin
            prism_addr_d  = addr_mem[rd_ptr_q];
            prism_wdata_d = data_mem[rd_ptr_q];
        end
        prism_reset_d  = (state_d == S_RESET) || (state_d == S_LOAD);
        prism_enable_d = (state_d == S_RUN);
        // Tracked in every state so a level already high on RUN entry
        // cannot look like a fresh edge.
        halt_d         = prism_halt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            halt_q         <= 1'b0;
            done_irq_q     <= 1'b0;
            prism_wr_q     <= 1'b0;
            prism_addr_q   <= '0;
            prism_wdata_q  <= '0;
            prism_reset_q  <= 1'b0;
            prism_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            halt_q         <= halt_d;
            done_irq_q     <= done_irq_d;
            prism_wr_q     <= prism_wr_d;
            prism_addr_q   <= prism_addr_d;
            prism_wdata_q  <= prism_wdata_d;
            prism_reset_q  <= prism_reset_d;
            prism_enable_q <= prism_enable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

`ifdef PRISM_SEQ_CKSUM_EN
    // ------------------------------------------------------------------
    // Loader checksum: folds in the popped word on the same edge that
    // puts it on prism_wdata, so cksum and prism_wr move together.
    // ------------------------------------------------------------------
    logic [31:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (start_acc) begin
            cksum_d = '0;
        end else if (load_pop) begin
            cksum_d = cksum_q ^ data_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    // Checksum disabled: no extra port or logic.
`endif

    assign push_ready   = !fifo_full;
    assign prism_addr   = prism_addr_q;
    assign prism_wr     = prism_wr_q;
    assign prism_wdata  = prism_wdata_q;
    assign prism_reset  = prism_reset_q;
    assign prism_enable = prism_enable_q;
    assign done_irq     = done_irq_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign state        = state_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_prism_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for prism_seq_ctrl (FIFO_DEPTH=4, RESET_CYCLES=2, ADDR_W=6).
// Expected PRISM writes are queued as stimulus is driven; a negedge monitor
// records every observed prism_wr beat, and the two queues are compared.
// -----------------------------------------------------------------------------
module tb_prism_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start, cmd_abort;
    logic        push_valid, push_ready;
    logic [5:0]  push_addr;
    logic [31:0] push_data;
    logic        host_wr;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic [5:0]  prism_addr;
    logic        prism_wr;
    logic [31:0] prism_wdata;
    logic        prism_reset, prism_enable, prism_halt;
    logic        irq_clr, done_irq, busy;
    logic [2:0]  state;
    logic [2:0]  fifo_level;
`ifdef PRISM_SEQ_CKSUM_EN
    logic [31:0] cksum;
`endif

    int tests = 0;
    int fails = 0;
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];

    always #5 clk = ~clk;

    prism_seq_ctrl #(.FIFO_DEPTH(4), .RESET_CYCLES(2), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data),
        .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .prism_addr(prism_addr), .prism_wr(prism_wr), .prism_wdata(prism_wdata),
        .prism_reset(prism_reset), .prism_enable(prism_enable),
        .prism_halt(prism_halt), .irq_clr(irq_clr), .done_irq(done_irq),
        .busy(busy), .state(state), .fifo_level(fifo_level)
`ifdef PRISM_SEQ_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    always @(negedge clk) begin
        if (!rst && prism_wr) obs_q.push_back({prism_addr, prism_wdata});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(state), 64'(s));
    endtask

    task automatic check_writes(input string tag);
        logic [38:0] o, e;
        while (exp_q.size() > 0) begin
            e = {1'b1, exp_q.pop_front()};
            if (obs_q.size() > 0) o = {1'b1, obs_q.pop_front()};
            else o = '0;
            check(tag, 64'(o), 64'(e));
        end
        check({tag, "_extra"}, 64'(obs_q.size()), 64'(0));
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
        push_valid = 1'b0; push_addr = '0; push_data = '0;
        host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        prism_halt = 1'b0; irq_clr = 1'b0;
        tick();
        tick();
        check("rst_state", 64'(state), 64'(0));
        check("rst_push_ready", 64'(push_ready), 64'(1));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_prism_wr", 64'(prism_wr), 64'(0));
        check("rst_prism_addr", 64'(prism_addr), 64'(0));
        check("rst_prism_wdata", 64'(prism_wdata), 64'(0));
        check("rst_prism_reset", 64'(prism_reset), 64'(0));
        check("rst_prism_enable", 64'(prism_enable), 64'(0));
        check("rst_done_irq", 64'(done_irq), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // Basic load and run
        push(6'h04, 32'hA5A50001); exp_q.push_back({6'h04, 32'hA5A50001});
        push(6'h08, 32'h0000FFFF); exp_q.push_back({6'h08, 32'h0000FFFF});
        check("t1_level", 64'(fifo_level), 64'(2));
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        check("t1_reset_a_state", 64'(state), 64'(1));
        check("t1_reset_a_prst", 64'(prism_reset), 64'(1));
        check("t1_reset_a_busy", 64'(busy), 64'(1));
        tick();
        check("t1_reset_b_state", 64'(state), 64'(1));
        check("t1_reset_b_prst", 64'(prism_reset), 64'(1));
        tick();
        check("t1_load_state", 64'(state), 64'(2));
        tick(); tick(); tick();
        check("t1_start_state", 64'(state), 64'(3));
        check("t1_start_prst", 64'(prism_reset), 64'(0));
        tick();
        check("t1_run_state", 64'(state), 64'(4));
        check("t1_run_enable", 64'(prism_enable), 64'(1));
        check_writes("t1_wr");

        // Halt edge -> DONE
        prism_halt = 1'b1; tick(); prism_halt = 1'b0;
        check("t2_done_state", 64'(state), 64'(5));
        check("t2_done_irq", 64'(done_irq), 64'(1));
        check("t2_done_enable", 64'(prism_enable), 64'(0));
        check("t2_done_busy", 64'(busy), 64'(0));

        // Restart with halt already high: start clears irq, level does not fire
        prism_halt = 1'b1;
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        check("t2_restart_irq", 64'(done_irq), 64'(0));
        check("t2_restart_state", 64'(state), 64'(1));
        wait_state(3'd4, 20, "t2_run");
        tick(); tick();
        check("t2_level_no_fire", 64'(state), 64'(4));
        prism_halt = 1'b0; tick();
        prism_halt = 1'b1; irq_clr = 1'b1; tick();
        prism_halt = 1'b0; irq_clr = 1'b0;
        check("t2_set_wins_state", 64'(state), 64'(5));
        check("t2_set_wins_irq", 64'(done_irq), 64'(1));
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("t2_irq_clr", 64'(done_irq), 64'(0));

        // Host writes take priority over the loader
        push(6'h20, 32'h11110000);
        push(6'h21, 32'h22220000);
        push(6'h22, 32'h33330000);
        check("t3_level3", 64'(fifo_level), 64'(3));
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        wait_state(3'd2, 10, "t3_load");
        host_wr = 1'b1; host_addr = 6'h10; host_wdata = 32'h1234;
        exp_q.push_back({6'h10, 32'h1234});
        exp_q.push_back({6'h10, 32'h1234});
        tick(); tick();
        host_wr = 1'b0;
        check("t3_level_hold", 64'(fifo_level), 64'(3));
        exp_q.push_back({6'h20, 32'h11110000});
        exp_q.push_back({6'h21, 32'h22220000});
        exp_q.push_back({6'h22, 32'h33330000});
        wait_state(3'd4, 20, "t3_run");
        check("t3_level0", 64'(fifo_level), 64'(0));
        check_writes("t3_wr");

        // Overfill while in RUN
        for (int i = 0; i < 4; i++) push(6'(i), 32'hC0DE0000 + 32'(i));
        check("t4_full_ready", 64'(push_ready), 64'(0));
        check("t4_full_level", 64'(fifo_level), 64'(4));
        push(6'h3F, 32'hDEADBEEF);
        check("t4_drop_level", 64'(fifo_level), 64'(4));
        cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        check("t4_abort_state", 64'(state), 64'(0));
        check("t4_abort_level", 64'(fifo_level), 64'(0));
        check("t4_abort_ready", 64'(push_ready), 64'(1));
        check("t4_abort_enable", 64'(prism_enable), 64'(0));

        // Start + abort together in LOAD
        push(6'h01, 32'h0000AAAA);
        push(6'h02, 32'h0000BBBB);
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        wait_state(3'd2, 10, "t5_load");
        cmd_start = 1'b1; cmd_abort = 1'b1; tick();
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check("t5_state", 64'(state), 64'(0));
        check("t5_level", 64'(fifo_level), 64'(0));
        check("t5_prst", 64'(prism_reset), 64'(0));
        tick(); tick(); tick();
        check("t5_state_after", 64'(state), 64'(0));
        check_writes("t5_wr");

`ifdef PRISM_SEQ_CKSUM_EN
        push(6'h05, 32'hFF00FF00); exp_q.push_back({6'h05, 32'hFF00FF00});
        push(6'h06, 32'h0F0F0F0F); exp_q.push_back({6'h06, 32'h0F0F0F0F});
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        wait_state(3'd4, 20, "t6_run");
        check("t6_cksum", 64'(cksum), 64'(32'hF00FF00F));
        check_writes("t6_wr");
        prism_halt = 1'b1; tick(); prism_halt = 1'b0;
        check("t6_done", 64'(state), 64'(5));
        cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        check("t6_cksum_clr", 64'(cksum), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
